// File: rtl/pwm_generator.sv
// -----------------------------------------------------------------------------
// pwm_generator
//
// Responder end of the steering PWM handshake. It takes ratio/direction
// requests qualified by pwm_update and drives the motor PWM pin and the
// direction pin. A new ratio is applied only at a period boundary. A direction
// reversal while the bridge is driving inserts one full period of low output
// before the new direction is applied. This dead band protects the H-bridge.
//
// Parameters:
//   PRESCALE    clock cycles per PWM counter step (1..256); period = 255*PRESCALE
//   PRESCALE_W  width of the prescaler counter
//
// Ports:
//   clock          main clock
//   reset_n        asynchronous active-low reset
//   pwm_enable     0 forces the block to DISABLED
//   pwm_update     level request to apply pwm_ratio / pwm_direction
//   pwm_ratio      requested high time out of 255
//   pwm_direction  requested motor direction
//   pwm_done       one-cycle pulse: a requested ratio was loaded at a boundary
//   pwm_signal     PWM pin to the motor driver
//   dir_out        direction pin to the motor driver
//   period_start   one-cycle pulse following each period boundary (debug)
// -----------------------------------------------------------------------------
module pwm_generator #(
    parameter int unsigned PRESCALE   = 4,
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       pwm_enable,
    input  logic       pwm_update,
    input  logic [7:0] pwm_ratio,
    input  logic       pwm_direction,
    output logic       pwm_done,
    output logic       pwm_signal,
    output logic       dir_out,
    output logic       period_start
);

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_RUN      = 2'd1,
        ST_DEADBAND = 2'd2
    } state_e;

    localparam logic [PRESCALE_W-1:0] PRESCALE_LAST = PRESCALE_W'(PRESCALE - 1);
    localparam logic [7:0]            COUNT_LAST    = 8'd254;

    state_e                state_q, state_d;
    logic [PRESCALE_W-1:0] prescaler_q, prescaler_d;
    logic [7:0]            counter_q, counter_d;
    logic [7:0]            active_ratio_q, active_ratio_d;
    logic                  pending_q, pending_d;
    logic                  done_q, done_d;
    logic                  signal_q, signal_d;
    logic                  dir_q, dir_d;
    logic                  period_start_q, period_start_d;

    logic tick;
    logic boundary;
    logic load_req;

    assign tick     = (prescaler_q == PRESCALE_LAST);
    assign boundary = (state_q != ST_DISABLED) && tick && (counter_q == COUNT_LAST);
    // A request that arrives on the boundary cycle itself is still honoured.
    assign load_req = pending_q | pwm_update;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d        = state_q;
        prescaler_d    = prescaler_q;
        counter_d      = counter_q;
        active_ratio_d = active_ratio_q;
        pending_d      = pending_q;
        done_d         = 1'b0;
        signal_d       = signal_q;
        dir_d          = dir_q;
        period_start_d = boundary;

        case (state_q)
            ST_DISABLED: begin
                // Everything held at zero. The direction pin keeps its last value.
                prescaler_d    = '0;
                counter_d      = '0;
                pending_d      = 1'b0;
                active_ratio_d = '0;
                signal_d       = 1'b0;
                if (pwm_enable) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN, ST_DEADBAND: begin
                if (tick) begin
                    prescaler_d = '0;
                    counter_d   = (counter_q == COUNT_LAST) ? 8'd0 : counter_q + 8'd1;
                end else begin
                    prescaler_d = prescaler_q + PRESCALE_W'(1);
                end

                // The ratio only changes at a boundary. The compare against the
                // current counter therefore never glitches mid-period.
                signal_d = (counter_q < active_ratio_q);

                if (pwm_update) begin
                    pending_d = 1'b1;
                end

                if (boundary) begin
                    if (state_q == ST_DEADBAND) begin
                        // Dead band served. Apply whatever is requested now,
                        // even if the direction has reverted meanwhile.
                        active_ratio_d = pwm_ratio;
                        dir_d          = pwm_direction;
                        pending_d      = 1'b0;
                        done_d         = 1'b1;
                        state_d        = ST_RUN;
                    end else if (load_req) begin
                        if ((pwm_direction == dir_q) || (active_ratio_q == 8'd0)) begin
                            active_ratio_d = pwm_ratio;
                            dir_d          = pwm_direction;
                            pending_d      = 1'b0;
                            done_d         = 1'b1;
                        end else begin
                            // Reversal while driving: hold the output low for a
                            // full period. Keep the request pending.
                            active_ratio_d = '0;
                            state_d        = ST_DEADBAND;
                        end
                    end
                end
            end

            default: begin
                state_d = ST_DISABLED;
            end
        endcase

        // Disable wins from any state. Pending requests are dropped silently.
        if (!pwm_enable) begin
            state_d        = ST_DISABLED;
            prescaler_d    = '0;
            counter_d      = '0;
            pending_d      = 1'b0;
            active_ratio_d = '0;
            signal_d       = 1'b0;
            done_d         = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_DISABLED;
            prescaler_q    <= '0;
            counter_q      <= '0;
            active_ratio_q <= '0;
            pending_q      <= 1'b0;
            done_q         <= 1'b0;
            signal_q       <= 1'b0;
            dir_q          <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples the
            // pre-edge value of every other register.
            state_q        <= state_d;
            prescaler_q    <= prescaler_d;
            counter_q      <= counter_d;
            active_ratio_q <= active_ratio_d;
            pending_q      <= pending_d;
            done_q         <= done_d;
            signal_q       <= signal_d;
            dir_q          <= dir_d;
            period_start_q <= period_start_d;
        end
    end

    assign pwm_done     = done_q;
    assign pwm_signal   = signal_q;
    assign dir_out      = dir_q;
    assign period_start = period_start_q;

endmodule
